sdram_arbiter: RTL

Shares the single SDRAM controller command port between three requesters: the ioctl ROM loader, the V810 data port and the V810 instruction-fetch port. It sits in `mycore` between those clients and `sdram`, in the `clk_ram` domain. It runs one transaction at a time. The loader has absolute priority; the two CPU ports alternate round-robin. A watchdog recovers from a lost controller acknowledge.

---
 rtl/sdram_arb_pkg.sv | 27 ++
 rtl/sdram_arb_pick.sv | 31 +++
 rtl/sdram_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types for the SDRAM command-port arbiter
package sdram_arb_pkg;

  localparam int NPORTS   = 3;
  // Widest byte address the command struct can carry; the top slices it down to AW.
  localparam int ADDR_MAX = 32;

  typedef enum logic [1:0] {
    LOADER = 2'd0,
    CPU_D  = 2'd1,
    CPU_I  = 2'd2
  } port_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                we;
    logic [ADDR_MAX-1:0] addr;
    logic [15:0]         din;
    logic [1:0]          be;
  } sd_cmd_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational winner selection among eligible ports
// Loader always wins; the two CPU ports alternate, the one not served last going first.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] elig,
  input  port_t             last_cpu,
  output logic [NPORTS-1:0] grant,
  output logic              valid
);

  always_comb begin
    grant = '0;
    if (elig[LOADER]) begin
      grant[LOADER] = 1'b1;
    end else if (elig[CPU_D] && elig[CPU_I]) begin
      if (last_cpu == CPU_D) begin
        grant[CPU_I] = 1'b1;
      end else begin
        grant[CPU_D] = 1'b1;
      end
    end else if (elig[CPU_D]) begin
      grant[CPU_D] = 1'b1;
    end else if (elig[CPU_I]) begin
      grant[CPU_I] = 1'b1;
    end
  end

  assign valid = |elig;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - one-at-a-time arbiter for the shared SDRAM controller command port
// Loader has absolute priority, CPU data/fetch alternate; a watchdog recovers from a lost sd_ack.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW      = 25,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_ram,
  input  logic          reset_n,
  input  logic          ld_active,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [15:0]   p0_din,
  input  logic [1:0]    p0_be,
  output logic [15:0]   p0_dout,
  output logic          p0_ack,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [15:0]   p1_din,
  input  logic [1:0]    p1_be,
  output logic [15:0]   p1_dout,
  output logic          p1_ack,

  input  logic          p2_req,
  input  logic          p2_we,
  input  logic [AW-1:0] p2_addr,
  input  logic [15:0]   p2_din,
  input  logic [1:0]    p2_be,
  output logic [15:0]   p2_dout,
  output logic          p2_ack,

  output logic          sd_req,
  output logic          sd_we,
  output logic [AW-1:0] sd_addr,
  output logic [15:0]   sd_din,
  output logic [1:0]    sd_be,
  input  logic [15:0]   sd_dout,
  input  logic          sd_ack,

  output logic          err_timeout,
  output logic          busy
);

  // The counter only has to reach TIMEOUT-1: the expiring WAIT cycle is the TIMEOUT-th one.
  localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t              state_q, state_d;
  port_t                   owner_q, last_cpu_q, grant_port;
  sd_cmd_t                 cmd_q, grant_cmd;
  logic [NPORTS-1:0]       req, elig, grant, ack_q;
  logic [NPORTS-1:0][15:0] dout_q;
  logic [CW-1:0]           wd_cnt_q;
  logic                    grant_valid;
  logic                    take, done, expire;
  logic                    unused_addr_hi;

  assign req  = {p2_req, p1_req, p0_req};
  // A port being acked this cycle is masked so its still-high request is not granted twice.
  assign elig = req & ~ack_q & {~ld_active, ~ld_active, 1'b1};

  sdram_arb_pick u_pick (
    .elig     (elig),
    .last_cpu (last_cpu_q),
    .grant    (grant),
    .valid    (grant_valid)
  );

  always_comb begin
    grant_port = LOADER;
    grant_cmd  = '{we: p0_we, addr: ADDR_MAX'(p0_addr), din: p0_din, be: p0_be};
    if (grant[CPU_D]) begin
      grant_port = CPU_D;
      grant_cmd  = '{we: p1_we, addr: ADDR_MAX'(p1_addr), din: p1_din, be: p1_be};
    end else if (grant[CPU_I]) begin
      grant_port = CPU_I;
      grant_cmd  = '{we: p2_we, addr: ADDR_MAX'(p2_addr), din: p2_din, be: p2_be};
    end
  end

  always_ff @(posedge clk_ram) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sd_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && wd_cnt_q == TO_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ram) begin
    if (!reset_n) begin
      cmd_q       <= '0;
      owner_q     <= LOADER;
      last_cpu_q  <= CPU_I;
      wd_cnt_q    <= '0;
      ack_q       <= '0;
      dout_q      <= '0;
      err_timeout <= 1'b0;
    end else begin
      ack_q       <= '0;
      err_timeout <= 1'b0;
      if (take) begin
        cmd_q    <= grant_cmd;
        owner_q  <= grant_port;
        wd_cnt_q <= '0;
        if (grant_port != LOADER) begin
          last_cpu_q <= grant_port;
        end
      end
      if (state_q == WAIT && TIMEOUT != 0) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (done) begin
        ack_q[owner_q]  <= 1'b1;
        dout_q[owner_q] <= sd_dout;
      end
      if (expire) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign sd_req  = (state_q == ISSUE) || (state_q == WAIT);
  assign busy    = (state_q != IDLE);
  assign sd_we   = cmd_q.we;
  assign sd_addr = cmd_q.addr[AW-1:0];
  assign sd_din  = cmd_q.din;
  assign sd_be   = cmd_q.be;

  assign unused_addr_hi = ^(cmd_q.addr >> AW);

  assign p0_ack  = ack_q[LOADER];
  assign p1_ack  = ack_q[CPU_D];
  assign p2_ack  = ack_q[CPU_I];
  assign p0_dout = dout_q[LOADER];
  assign p1_dout = dout_q[CPU_D];
  assign p2_dout = dout_q[CPU_I];

endmodule
